branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Execute-stage branch resolver for the ENIAC-V core, directly upstream of branch_predictor.
//  Evaluates each conditional branch and compares the real outcome with the fetch-time prediction.
//  Drives the predictor's branch/branch_taken update pair.
//  On a mispredict, issues a multi-cycle pipeline flush and a redirect PC.
// PARAMETERS
//  XLEN          32  datapath / PC width
//  FLUSH_CYCLES  2   cycles flush stays high per mispredict (>=1)
//  CNT_W         16  width of the performance counters
// PORTS
//  clock             in   1       rising-edge clock
//  reset             in   1       synchronous, active-high
//  ex_valid          in   1       a conditional branch is present in EX
//  stall             in   1       EX frozen; inputs not consumed
//  ex_pc             in   XLEN    PC of the branch
//  ex_imm            in   XLEN    sign-extended B-immediate (bit0 = 0)
//  ex_rs1, ex_rs2    in   XLEN    operand values
//  ex_funct3         in   3       branch type
//  ex_pred_taken     in   1       prediction carried from fetch
//  upd_branch        out  1       -> branch_predictor.branch
//  upd_taken         out  1       -> branch_predictor.branch_taken
//  mispredict        out  1       resolved outcome differs from prediction
//  redirect_pc       out  XLEN    correct next PC; meaningful only when mispredict=1
//  flush             out  1       squash younger instructions
//  branch_count      out  CNT_W   branches resolved, saturating
//  mispredict_count  out  CNT_W   mispredicts, saturating
// BEHAVIOUR
//  - Reset: every output is 0, FSM=IDLE, and both counters are cleared.
//  - Accept: ex_valid && !stall && state==IDLE at a posedge. Results are registered and appear on the
//    next cycle (latency 1). upd_branch, upd_taken and mispredict are one-cycle pulses.
//  - Compare by funct3: 000 BEQ (==), 001 BNE (!=), 100 BLT (signed <), 101 BGE (signed >=),
//    110 BLTU (unsigned <), 111 BGEU (unsigned >=).
//    010 and 011 are resolved as not-taken, with upd_branch still pulsed.
//  - taken target = ex_pc+ex_imm; fall-through = ex_pc+4. Both wrap modulo 2^XLEN.
//  - mispredict = taken ^ ex_pred_taken. redirect_pc = taken ? target : fall-through.
//  - FSM:
//      IDLE -> FLUSH when an accepted branch mispredicts. flush goes high together with the
//      mispredict pulse and stays high exactly FLUSH_CYCLES cycles (down-counter).
//      FLUSH -> IDLE when the counter expires.
//      While in FLUSH, ex_valid is ignored: the instruction is squashed, not resolved, and not counted.
//  - Back-to-back: correct predictions are accepted every cycle.
//    A branch presented in the cycle the flush ends (counter->0) is not accepted. It is accepted from the next cycle.
//  - stall=1 in IDLE: nothing is accepted and no pulses are produced. A pulse already registered still shows
//    for its single cycle. stall does not pause the FLUSH countdown.
//  - Counters:
//      branch_count increments on each accept.
//      mispredict_count increments on each accepted mispredict.
//      Both saturate at all-ones and never wrap.
//  - Reset mid-flush: flush drops on the next edge and the FSM returns to IDLE.
// STRUCTURE
//  - Shared package eniac_pkg: BR_BEQ..BR_BGEU funct3 localparams and the state enum {IDLE, FLUSH}.
//  - Sub-module branch_cmp: purely combinational, (rs1, rs2, funct3) -> taken.
//    Top level holds the stage register, flush FSM/counter and perf counters.
// TESTING
//  1. BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred=0:
//     next cycle upd_branch=1, upd_taken=1, mispredict=1, redirect_pc=0x120; flush high 2 cycles.
//  2. BLT rs1=0xFFFFFFFF, rs2=1, pred=1 -> taken, no mispredict, flush=0.
//     Same operands as BLTU with pred=1 -> not taken, mispredict=1, redirect_pc=pc+4.
//  3. Three back-to-back correctly predicted BNEs -> three consecutive upd_branch pulses; branch_count=3, flush never set.
//  4. Mispredict, then ex_valid held high through the flush -> squashed branches are not counted.
//     The first accept lands the cycle after flush falls.
//  5. stall=1 with ex_valid=1 for 4 cycles -> no upd_branch and counters unchanged. Releasing stall -> one accept.
//  6. Force mispredict_count=0xFFFF then mispredict -> it holds 0xFFFF.
//     Reset asserted during flush -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared ENIAC-V execute-stage definitions: branch funct3 encodings and the
// flush FSM state type used by the branch resolver.
package eniac_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch bundle: the pipeline (master) presents a branch, the
// resolver (slave) returns predictor updates, redirect/flush and counters.
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             ex_valid;
    logic             stall;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [2:0]       ex_funct3;
    logic             ex_pred_taken;
    logic             upd_branch;
    logic             upd_taken;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output ex_valid, stall, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_funct3, ex_pred_taken,
        input  upd_branch, upd_taken, mispredict, redirect_pc, flush,
               branch_count, mispredict_count
    );

    modport slave (
        input  ex_valid, stall, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_funct3, ex_pred_taken,
        output upd_branch, upd_taken, mispredict, redirect_pc, flush,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_unit_cmp.sv
// Combinational branch condition evaluator: (rs1, rs2, funct3) -> taken.
module branch_cmp
    import eniac_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken
);

    // Reserved encodings 010/011 fall through the default as not-taken.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            BR_BEQ:  taken = (rs1 == rs2);
            BR_BNE:  taken = (rs1 != rs2);
            BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            BR_BLTU: taken = (rs1 <  rs2);
            BR_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: registers the resolved outcome, updates the
// predictor, and on a mispredict raises a fixed-length flush with a redirect PC.
module branch_resolve_unit
    import eniac_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    branch_resolve_unit_if.slave br
);

    localparam int              FCW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    br_state_e        state_q, state_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d;
    logic             flush_q, flush_d;
    logic             upd_branch_q, upd_branch_d;
    logic             upd_taken_q, upd_taken_d;
    logic             mispredict_q, mispredict_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic             taken_s;
    logic             accept_s;
    logic             miss_s;
    logic [XLEN-1:0]  target_s;
    logic [XLEN-1:0]  fall_s;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1    (br.ex_rs1),
        .rs2    (br.ex_rs2),
        .funct3 (br.ex_funct3),
        .taken  (taken_s)
    );

    // Resolve the presented branch; squashed (FLUSH) or stalled branches are never accepted.
    always_comb begin
        accept_s = br.ex_valid && !br.stall && (state_q == IDLE);
        miss_s   = taken_s ^ br.ex_pred_taken;
        target_s = br.ex_pc + br.ex_imm;
        fall_s   = br.ex_pc + PC_STEP;
    end

    // Next-state for the flush FSM, result stage and saturating counters.
    always_comb begin
        state_d            = state_q;
        fcnt_d             = fcnt_q;
        flush_d            = 1'b0;
        upd_branch_d       = accept_s;
        upd_taken_d        = accept_s && taken_s;
        mispredict_d       = accept_s && miss_s;
        redirect_pc_d      = redirect_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (accept_s) begin
            redirect_pc_d = taken_s ? target_s : fall_s;
        end else begin
            redirect_pc_d = redirect_pc_q;
        end

        if (accept_s && (branch_count_q != CNT_MAX)) begin
            branch_count_d = branch_count_q + CNT_W'(1);
        end else begin
            branch_count_d = branch_count_q;
        end

        if (accept_s && miss_s && (mispredict_count_q != CNT_MAX)) begin
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end else begin
            mispredict_count_d = mispredict_count_q;
        end

        // The counter holds the number of flush cycles still to come after the current one.
        case (state_q)
            IDLE: begin
                if (accept_s && miss_s) begin
                    state_d = FLUSH;
                    fcnt_d  = FCW'(FLUSH_CYCLES - 1);
                    flush_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end
            end
            FLUSH: begin
                if (fcnt_q == FCW'(0)) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end else begin
                    fcnt_d  = fcnt_q - FCW'(1);
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = FCW'(0);
                flush_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= IDLE;
            fcnt_q             <= FCW'(0);
            flush_q            <= 1'b0;
            upd_branch_q       <= 1'b0;
            upd_taken_q        <= 1'b0;
            mispredict_q       <= 1'b0;
            redirect_pc_q      <= {XLEN{1'b0}};
            branch_count_q     <= {CNT_W{1'b0}};
            mispredict_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q            <= state_d;
            fcnt_q             <= fcnt_d;
            flush_q            <= flush_d;
            upd_branch_q       <= upd_branch_d;
            upd_taken_q        <= upd_taken_d;
            mispredict_q       <= mispredict_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign br.upd_branch       = upd_branch_q;
    assign br.upd_taken        = upd_taken_q;
    assign br.mispredict       = mispredict_q;
    assign br.redirect_pc      = redirect_pc_q;
    assign br.flush            = flush_q;
    assign br.branch_count     = branch_count_q;
    assign br.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed vectors for compares,
// flush timing, squash/stall behaviour, counters, saturation and reset.
module tb_branch_resolve_unit;
    import eniac_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bif ();
    branch_resolve_unit_if #(.XLEN(32), .CNT_W(2))  sif ();

    branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .br    (bif)
    );

    branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clock (clock),
        .reset (reset),
        .br    (sif)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        bif.ex_valid      = 1'b1;
        bif.ex_funct3     = f3;
        bif.ex_rs1        = rs1;
        bif.ex_rs2        = rs2;
        bif.ex_pc         = pc;
        bif.ex_imm        = imm;
        bif.ex_pred_taken = pred;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".upd_branch"}, 64'(bif.upd_branch), 64'd0);
        check({tag, ".upd_taken"},  64'(bif.upd_taken),  64'd0);
        check({tag, ".mispredict"}, 64'(bif.mispredict), 64'd0);
        check({tag, ".redirect"},   64'(bif.redirect_pc), 64'd0);
        check({tag, ".flush"},      64'(bif.flush),      64'd0);
        check({tag, ".bcount"},     64'(bif.branch_count), 64'd0);
        check({tag, ".mcount"},     64'(bif.mispredict_count), 64'd0);
    endtask

    initial begin
        bif.ex_valid = 1'b0; bif.stall = 1'b0; bif.ex_pc = 32'd0; bif.ex_imm = 32'd0;
        bif.ex_rs1 = 32'd0; bif.ex_rs2 = 32'd0; bif.ex_funct3 = 3'd0; bif.ex_pred_taken = 1'b0;
        sif.ex_valid = 1'b0; sif.stall = 1'b0; sif.ex_pc = 32'h40; sif.ex_imm = 32'h8;
        sif.ex_rs1 = 32'd1; sif.ex_rs2 = 32'd2; sif.ex_funct3 = BR_BEQ; sif.ex_pred_taken = 1'b1;

        cyc(); cyc();
        check_all_zero("reset");
        reset = 1'b0;

        // 1. BEQ taken, predicted not-taken
        set_br(BR_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        cyc();
        bif.ex_valid = 1'b0;
        check("t1.upd_branch", 64'(bif.upd_branch), 64'd1);
        check("t1.upd_taken",  64'(bif.upd_taken),  64'd1);
        check("t1.mispredict", 64'(bif.mispredict), 64'd1);
        check("t1.redirect",   64'(bif.redirect_pc), 64'h120);
        check("t1.flush_c1",   64'(bif.flush), 64'd1);
        cyc();
        check("t1.flush_c2",   64'(bif.flush), 64'd1);
        check("t1.pulse_end",  64'(bif.upd_branch), 64'd0);
        check("t1.miss_end",   64'(bif.mispredict), 64'd0);
        cyc();
        check("t1.flush_c3",   64'(bif.flush), 64'd0);
        check("t1.bcount",     64'(bif.branch_count), 64'd1);
        check("t1.mcount",     64'(bif.mispredict_count), 64'd1);

        // 2. BLT signed taken (correct), then BLTU same operands not taken (mispredict)
        set_br(BR_BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1);
        cyc();
        check("t2.blt_taken",  64'(bif.upd_taken),  64'd1);
        check("t2.blt_miss",   64'(bif.mispredict), 64'd0);
        check("t2.blt_flush",  64'(bif.flush),      64'd0);
        set_br(BR_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1);
        cyc();
        bif.ex_valid = 1'b0;
        check("t2.bltu_taken", 64'(bif.upd_taken),  64'd0);
        check("t2.bltu_miss",  64'(bif.mispredict), 64'd1);
        check("t2.bltu_redir", 64'(bif.redirect_pc), 64'h204);
        check("t2.bltu_flush", 64'(bif.flush),      64'd1);
        cyc(); cyc();
        check("t2.flush_done", 64'(bif.flush), 64'd0);
        check("t2.bcount",     64'(bif.branch_count), 64'd3);
        check("t2.mcount",     64'(bif.mispredict_count), 64'd2);

        // Reserved funct3 010: not taken but still an update; BGE signed 1 >= -1 taken
        set_br(3'b010, 32'd9, 32'd9, 32'h300, 32'h10, 1'b0);
        cyc();
        check("rsv.upd_branch", 64'(bif.upd_branch), 64'd1);
        check("rsv.upd_taken",  64'(bif.upd_taken),  64'd0);
        check("rsv.miss",       64'(bif.mispredict), 64'd0);
        set_br(BR_BGE, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'h10, 1'b1);
        cyc();
        check("bge.taken", 64'(bif.upd_taken),  64'd1);
        check("bge.miss",  64'(bif.mispredict), 64'd0);

        // Target wraps modulo 2^32
        set_br(BR_BGEU, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h20, 1'b0);
        cyc();
        bif.ex_valid = 1'b0;
        check("wrap.redirect", 64'(bif.redirect_pc), 64'h10);
        check("wrap.miss",     64'(bif.mispredict), 64'd1);
        cyc(); cyc();

        // 3. Fresh reset, three back-to-back correctly predicted BNEs
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_br(BR_BNE, 32'd1, 32'd2, 32'h400, 32'h8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("t3.upd_%0d", i),   64'(bif.upd_branch), 64'd1);
            check($sformatf("t3.flush_%0d", i), 64'(bif.flush),      64'd0);
        end
        bif.ex_valid = 1'b0;
        cyc();
        check("t3.pulse_end", 64'(bif.upd_branch), 64'd0);
        check("t3.bcount",    64'(bif.branch_count), 64'd3);
        check("t3.mcount",    64'(bif.mispredict_count), 64'd0);

        // 4. Mispredict, then valid held through the flush: squashed branches not counted
        set_br(BR_BEQ, 32'd1, 32'd2, 32'h500, 32'h80, 1'b1);
        cyc();
        check("t4.miss",     64'(bif.mispredict), 64'd1);
        check("t4.redirect", 64'(bif.redirect_pc), 64'h504);
        check("t4.bcount_a", 64'(bif.branch_count), 64'd4);
        set_br(BR_BEQ, 32'd3, 32'd3, 32'h600, 32'h80, 1'b1);
        cyc();
        check("t4.sq_upd1",  64'(bif.upd_branch), 64'd0);
        check("t4.flush_c2", 64'(bif.flush), 64'd1);
        cyc();
        check("t4.sq_upd2",  64'(bif.upd_branch), 64'd0);
        check("t4.flush_c3", 64'(bif.flush), 64'd0);
        check("t4.bcount_b", 64'(bif.branch_count), 64'd4);
        cyc();
        check("t4.accept",   64'(bif.upd_branch), 64'd1);
        check("t4.bcount_c", 64'(bif.branch_count), 64'd5);
        bif.stall = 1'b1;

        // 5. Stall with valid held for 4 cycles, then release
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("t5.stall_upd_%0d", i), 64'(bif.upd_branch), 64'd0);
        end
        check("t5.bcount_stall", 64'(bif.branch_count), 64'd5);
        bif.stall = 1'b0;
        cyc();
        bif.ex_valid = 1'b0;
        check("t5.release_upd", 64'(bif.upd_branch), 64'd1);
        cyc();
        check("t5.single",      64'(bif.upd_branch), 64'd0);
        check("t5.bcount",      64'(bif.branch_count), 64'd6);

        // Stall does not pause the flush countdown
        set_br(BR_BEQ, 32'd1, 32'd2, 32'h700, 32'h80, 1'b1);
        cyc();
        bif.stall = 1'b1;
        check("stf.flush_c1", 64'(bif.flush), 64'd1);
        cyc();
        check("stf.flush_c2", 64'(bif.flush), 64'd1);
        cyc();
        check("stf.flush_c3", 64'(bif.flush), 64'd0);
        check("stf.mcount",   64'(bif.mispredict_count), 64'd2);
        bif.stall = 1'b0;
        bif.ex_valid = 1'b0;

        // 6b. Reset asserted during flush
        set_br(BR_BEQ, 32'd1, 32'd2, 32'h800, 32'h80, 1'b1);
        cyc();
        bif.ex_valid = 1'b0;
        check("rmf.flush_on", 64'(bif.flush), 64'd1);
        reset = 1'b1;
        cyc();
        check_all_zero("rmf");
        reset = 1'b0;
        cyc();
        check("rmf.flush_stays", 64'(bif.flush), 64'd0);

        // 6a. Saturation on the narrow-counter instance (all-ones = 3): 5 mispredicts, one every 3 cycles
        sif.ex_valid = 1'b1;
        cyc();
        check("sat.mcount_1", 64'(sif.mispredict_count), 64'd1);
        for (int i = 0; i < 13; i++) cyc();
        sif.ex_valid = 1'b0;
        check("sat.mcount", 64'(sif.mispredict_count), 64'd3);
        check("sat.bcount", 64'(sif.branch_count), 64'd3);
        cyc(); cyc(); cyc();
        check("sat.hold",   64'(sif.mispredict_count), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
